// File: rtl/k_and_s_pkg.sv
// ============================================================================
// k_and_s_pkg : shared types and encodings for the K&S datapath
// Revision    : 1.0
// ============================================================================
`default_nettype none

package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR, I_SHL, I_SHR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO,
    I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_SHL    = 8'hA5;
  localparam logic [7:0] OPC_SHR    = 8'hA6;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BZERO  = 8'h02;
  localparam logic [7:0] OPC_BNEG   = 8'h03;
  localparam logic [7:0] OPC_BOV    = 8'h05;
  localparam logic [7:0] OPC_BNOV   = 8'h06;
  localparam logic [7:0] OPC_BNNEG  = 8'h0A;
  localparam logic [7:0] OPC_BNZERO = 8'h0B;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;

endpackage

`default_nettype wire

// File: rtl/ks_data_path_gen2_reg_file.sv
// ============================================================================
// ks_reg_file : NUM_REGS x DATA_W register file, 1 write / 2 async read ports
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ks_reg_file
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]           rdata_a,
  output logic [DATA_W-1:0]           rdata_b
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

`default_nettype wire

// File: rtl/ks_data_path_gen2.sv
// ============================================================================
// ks_data_path_gen2 : K&S datapath (IR, PC, reg file, ALU, flags, decoder)
// Optional shift unit enabled by defining KS_DP_SHIFT_EN.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module ks_data_path_gen2
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [2:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  localparam int RSEL_W = $clog2(NUM_REGS);
  localparam int MSB    = DATA_W - 1;

  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              zero_q, zero_d, neg_q, neg_d, uov_q, uov_d, sov_q, sov_d;

  decoded_instruction_type instr;
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] mem_addr;
  logic [RSEL_W-1:0] a_addr, b_addr, c_addr;
  logic [DATA_W-1:0] bus_a, bus_b, bus_c;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] alu_r;
  logic              alu_uov, alu_sov, alu_zero, alu_neg;

  // Only some IR bits feed the decoder; fold the rest away explicitly.
  logic unused_ir;
  assign unused_ir = ^ir_q;

  always_comb begin
    opcode   = ir_q[DATA_W-1 -: 8];
    instr    = I_NOP;
    mem_addr = '0;
    a_addr   = '0;
    b_addr   = '0;
    c_addr   = '0;
    case (opcode)
      OPC_LOAD:   instr = I_LOAD;
      OPC_STORE:  instr = I_STORE;
      OPC_MOVE:   instr = I_MOVE;
      OPC_ADD:    instr = I_ADD;
      OPC_SUB:    instr = I_SUB;
      OPC_AND:    instr = I_AND;
      OPC_OR:     instr = I_OR;
`ifdef KS_DP_SHIFT_EN
      OPC_SHL:    instr = I_SHL;
      OPC_SHR:    instr = I_SHR;
`endif
      OPC_BRANCH: instr = I_BRANCH;
      OPC_BZERO:  instr = I_BZERO;
      OPC_BNEG:   instr = I_BNEG;
      OPC_BOV:    instr = I_BOV;
      OPC_BNOV:   instr = I_BNOV;
      OPC_BNNEG:  instr = I_BNNEG;
      OPC_BNZERO: instr = I_BNZERO;
      OPC_HALT:   instr = I_HALT;
      default:    instr = I_NOP;
    endcase
    if (instr != I_NOP) begin
      mem_addr = ir_q[ADDR_W-1:0];
      a_addr   = ir_q[RSEL_W-1:0];
      b_addr   = ir_q[2*RSEL_W-1:RSEL_W];
      c_addr   = ir_q[3*RSEL_W-1:2*RSEL_W];
      case (instr)
        I_LOAD:  c_addr = ir_q[ADDR_W+RSEL_W-1:ADDR_W];
        I_STORE: a_addr = ir_q[ADDR_W+RSEL_W-1:ADDR_W];
        I_MOVE: begin
          c_addr = ir_q[2*RSEL_W-1:RSEL_W];
          a_addr = ir_q[RSEL_W-1:0];
          b_addr = ir_q[RSEL_W-1:0];
        end
        default: ;
      endcase
    end
  end

  ks_reg_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (write_reg_enable),
    .waddr   (c_addr),
    .wdata   (bus_c),
    .raddr_a (a_addr),
    .raddr_b (b_addr),
    .rdata_a (bus_a),
    .rdata_b (bus_b)
  );

  always_comb begin
    sum_ext = '0;
    alu_r   = '0;
    alu_uov = 1'b0;
    alu_sov = 1'b0;
    case (operation)
      ALU_ADD: begin
        sum_ext = {1'b0, bus_a} + {1'b0, bus_b};
        alu_r   = sum_ext[DATA_W-1:0];
        alu_uov = sum_ext[DATA_W];
        alu_sov = (bus_a[MSB] == bus_b[MSB]) && (alu_r[MSB] != bus_a[MSB]);
      end
      ALU_AND: alu_r = bus_a & bus_b;
      ALU_OR:  alu_r = bus_a | bus_b;
      ALU_SUB: begin
        // The extension bit of the widened difference is the borrow.
        sum_ext = {1'b0, bus_a} - {1'b0, bus_b};
        alu_r   = sum_ext[DATA_W-1:0];
        alu_uov = sum_ext[DATA_W];
        alu_sov = (bus_a[MSB] != bus_b[MSB]) && (alu_r[MSB] != bus_a[MSB]);
      end
`ifdef KS_DP_SHIFT_EN
      ALU_SHL: begin
        alu_r   = {bus_a[DATA_W-2:0], 1'b0};
        alu_uov = bus_a[MSB];
      end
      ALU_SHR: begin
        alu_r   = {1'b0, bus_a[DATA_W-1:1]};
        alu_uov = bus_a[0];
      end
`endif
      default: alu_r = '0;
    endcase
  end

  assign alu_zero = (alu_r == '0);
  assign alu_neg  = alu_r[MSB];
  assign bus_c    = c_sel ? data_in : alu_r;

  always_comb begin
    ir_d   = ir_enable ? data_in : ir_q;
    pc_d   = pc_q;
    if (pc_enable) begin
      pc_d = branch ? mem_addr : pc_q + ADDR_W'(1);
    end
    zero_d = zero_q;
    neg_d  = neg_q;
    uov_d  = uov_q;
    sov_d  = sov_q;
    if (flags_reg_enable) begin
      zero_d = alu_zero;
      neg_d  = alu_neg;
      uov_d  = alu_uov;
      sov_d  = alu_sov;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= '0;
      pc_q   <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      uov_q  <= 1'b0;
      sov_q  <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      pc_q   <= pc_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      uov_q  <= uov_d;
      sov_q  <= sov_d;
    end
  end

  assign decoded_instruction = instr;
  assign zero_op             = zero_q;
  assign neg_op              = neg_q;
  assign unsigned_overflow   = uov_q;
  assign signed_overflow     = sov_q;
  assign ram_addr            = addr_sel ? pc_q : mem_addr;
  assign data_out            = bus_a;

endmodule

`default_nettype wire

// File: tb/tb_ks_data_path_gen2.sv
// ============================================================================
// tb_ks_data_path_gen2 : directed + randomized bench with a behavioural model
// Revision             : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ks_data_path_gen2;
  import k_and_s_pkg::*;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 4;
`ifdef KS_DP_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    branch = 1'b0, pc_enable = 1'b0, ir_enable = 1'b0;
  logic                    addr_sel = 1'b1, c_sel = 1'b0;
  logic [2:0]              operation = 3'd0;
  logic                    write_reg_enable = 1'b0, flags_reg_enable = 1'b0;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       data_out;
  logic [DATA_W-1:0]       data_in = '0;

  always #5 clk = ~clk;

  ks_data_path_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .ram_addr            (ram_addr),
    .data_out            (data_out),
    .data_in             (data_in)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state of the datapath.
  int unsigned m_regs [NUM_REGS];
  int unsigned m_pc, m_ir;
  bit          m_z, m_n, m_u, m_s;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_decode(input int unsigned ir, output decoded_instruction_type ins,
                                       output int unsigned a, output int unsigned b,
                                       output int unsigned c, output int unsigned mem);
    int unsigned opc;
    opc = ir / 256;
    case (opc)
      'h81: ins = I_LOAD;   'h82: ins = I_STORE;  'h91: ins = I_MOVE;
      'hA1: ins = I_ADD;    'hA2: ins = I_SUB;    'hA3: ins = I_AND;
      'hA4: ins = I_OR;
      'hA5: ins = SHIFT_EN ? I_SHL : I_NOP;
      'hA6: ins = SHIFT_EN ? I_SHR : I_NOP;
      'h01: ins = I_BRANCH; 'h02: ins = I_BZERO;  'h03: ins = I_BNEG;
      'h05: ins = I_BOV;    'h06: ins = I_BNOV;   'h0A: ins = I_BNNEG;
      'h0B: ins = I_BNZERO; 'hFF: ins = I_HALT;
      default: ins = I_NOP;
    endcase
    a   = ir % NUM_REGS;
    b   = (ir / NUM_REGS) % NUM_REGS;
    c   = (ir / (NUM_REGS * NUM_REGS)) % NUM_REGS;
    mem = ir % (1 << ADDR_W);
    if (ins == I_LOAD)  c = (ir >> ADDR_W) % NUM_REGS;
    if (ins == I_STORE) a = (ir >> ADDR_W) % NUM_REGS;
    if (ins == I_MOVE) begin
      c = (ir / NUM_REGS) % NUM_REGS;
      a = ir % NUM_REGS;
      b = a;
    end
    if (ins == I_NOP) begin
      a = 0; b = 0; c = 0; mem = 0;
    end
  endfunction

  // Arithmetic on plain integers, overflow judged against the signed range.
  function automatic void model_alu(input int unsigned op, input int unsigned a, input int unsigned b,
                                    output int unsigned r, output bit z, output bit n,
                                    output bit u, output bit s);
    longint sa, sb, sr;
    longint unsigned full;
    sa = (a >= 32768) ? longint'(a) - 65536 : longint'(a);
    sb = (b >= 32768) ? longint'(b) - 65536 : longint'(b);
    r = 0; u = 0; s = 0;
    case (op)
      0: begin
        full = longint'(a) + longint'(b);
        r = int'(full % 65536);
        u = (full > 65535);
        sr = sa + sb;
        s = (sr > 32767) || (sr < -32768);
      end
      1: r = a & b;
      2: r = a | b;
      3: begin
        r = (a + 65536 - b) % 65536;
        u = (a < b);
        sr = sa - sb;
        s = (sr > 32767) || (sr < -32768);
      end
      4: if (SHIFT_EN) begin r = (a * 2) % 65536; u = (a >= 32768); end
      5: if (SHIFT_EN) begin r = a / 2; u = (a % 2) == 1; end
      default: r = 0;
    endcase
    z = (r == 0);
    n = (r >= 32768);
  endfunction

  task automatic check_all();
    decoded_instruction_type ins;
    int unsigned a, b, c, mem;
    model_decode(m_ir, ins, a, b, c, mem);
    check_val("ram_addr", 32'(ram_addr), addr_sel ? m_pc : mem);
    check_val("data_out", 32'(data_out), m_regs[a]);
    check_val("decoded", 32'(decoded_instruction), 32'(ins));
    check_val("zero", 32'(zero_op), 32'(m_z));
    check_val("neg", 32'(neg_op), 32'(m_n));
    check_val("uov", 32'(unsigned_overflow), 32'(m_u));
    check_val("sov", 32'(signed_overflow), 32'(m_s));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
    m_pc = 0; m_ir = 0; m_z = 0; m_n = 0; m_u = 0; m_s = 0;
  endtask

  // One clock cycle: called and returns at a falling edge.
  task automatic step(input bit br, input bit pe, input bit ie, input bit as, input bit cs,
                      input logic [2:0] op, input bit wre, input bit fre,
                      input logic [DATA_W-1:0] din);
    decoded_instruction_type ins;
    int unsigned a, b, c, mem, r, bc;
    bit z, n, u, s;
    branch = br; pc_enable = pe; ir_enable = ie; addr_sel = as; c_sel = cs;
    operation = op; write_reg_enable = wre; flags_reg_enable = fre; data_in = din;
    model_decode(m_ir, ins, a, b, c, mem);
    model_alu(int'(op), m_regs[a], m_regs[b], r, z, n, u, s);
    bc = cs ? int'(din) : r;
    @(posedge clk);
    if (wre) m_regs[c] = bc;
    if (fre) begin m_z = z; m_n = n; m_u = u; m_s = s; end
    if (pe)  m_pc = br ? mem : (m_pc + 1) % (1 << ADDR_W);
    if (ie)  m_ir = int'(din);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_step(input bit as);
    step(0, 0, 0, as, 0, 3'd0, 0, 0, 16'h0000);
  endtask

  task automatic load_ir(input logic [DATA_W-1:0] ir);
    step(0, 0, 1, 0, 0, 3'd0, 0, 0, ir);
  endtask

  task automatic load_reg(input int idx, input logic [DATA_W-1:0] val);
    load_ir(16'(32'h8100 | (idx << ADDR_W)));
    step(0, 0, 0, 0, 1, 3'd0, 1, 0, val);
  endtask

  // Assert reset between edges and check that state clears without a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    addr_sel = 1'b1;
    model_clear();
    #1;
    check_all();
    check_val("rst_decoded", 32'(decoded_instruction), 32'(I_NOP));
    check_val("rst_pc", 32'(ram_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [7:0] OPCS [18] = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
                                       8'hA6, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B,
                                       8'hFF, 8'h77};

  initial begin
    logic [7:0] opc;
    logic [DATA_W-1:0] din;
    model_clear();
    #3;
    check_all();
    check_val("reset_decoded", 32'(decoded_instruction), 32'(I_NOP));
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD r2 <- [0x1F], then STORE r2 to 0x03
    load_ir(16'h815F);
    check_val("load_addr", 32'(ram_addr), 32'h1F);
    check_val("load_decoded", 32'(decoded_instruction), 32'(I_LOAD));
    step(0, 0, 0, 0, 1, 3'd0, 1, 0, 16'hBEEF);
    load_ir(16'h8243);
    check_val("store_addr", 32'(ram_addr), 32'h03);
    check_val("store_data", 32'(data_out), 32'hBEEF);

    // ADD 0x7FFF + 0x0001 into r3
    load_reg(0, 16'h7FFF);
    load_reg(1, 16'h0001);
    load_ir(16'hA134);
    step(0, 0, 0, 0, 0, 3'd0, 1, 1, 16'h0000);
    check_val("add_ovf_neg", 32'(neg_op), 32'h1);
    check_val("add_ovf_sov", 32'(signed_overflow), 32'h1);
    check_val("add_ovf_uov", 32'(unsigned_overflow), 32'h0);
    check_val("add_ovf_zero", 32'(zero_op), 32'h0);
    load_ir(16'h8260);
    check_val("add_ovf_result", 32'(data_out), 32'h8000);

    // ADD 0xFFFF + 1 -> carry and zero
    load_reg(0, 16'hFFFF);
    load_ir(16'hA134);
    step(0, 0, 0, 0, 0, 3'd0, 1, 1, 16'h0000);
    check_val("add_carry_zero", 32'(zero_op), 32'h1);
    check_val("add_carry_uov", 32'(unsigned_overflow), 32'h1);

    // SUB 1 - 2 -> borrow, negative; then flags hold with enable low
    load_reg(0, 16'h0001);
    load_reg(1, 16'h0002);
    load_ir(16'hA234);
    step(0, 0, 0, 0, 0, 3'd3, 1, 1, 16'h0000);
    check_val("sub_uov", 32'(unsigned_overflow), 32'h1);
    check_val("sub_neg", 32'(neg_op), 32'h1);
    check_val("sub_sov", 32'(signed_overflow), 32'h0);
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, 16'h0000);
    check_val("flags_hold_uov", 32'(unsigned_overflow), 32'h1);
    check_val("flags_hold_neg", 32'(neg_op), 32'h1);
    load_ir(16'h8260);
    check_val("sub_result", 32'(data_out), 32'hFFFF);

    // PC: branch to 0x1F, wrap to 0, branch to 0x07
    load_ir(16'h011F);
    step(1, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000);
    check_val("pc_branch_1f", 32'(ram_addr), 32'h1F);
    step(0, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000);
    check_val("pc_wrap", 32'(ram_addr), 32'h00);
    load_ir(16'h0107);
    step(1, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000);
    check_val("pc_branch_07", 32'(ram_addr), 32'h07);

    // ALU op 100 on 0x8001
    load_reg(0, 16'h8001);
    load_ir(16'hA134);
    step(0, 0, 0, 0, 0, 3'd4, 1, 1, 16'h0000);
`ifdef KS_DP_SHIFT_EN
    check_val("shl_uov", 32'(unsigned_overflow), 32'h1);
    check_val("shl_zero", 32'(zero_op), 32'h0);
    load_ir(16'h8260);
    check_val("shl_result", 32'(data_out), 32'h0002);
`else
    check_val("op100_zero", 32'(zero_op), 32'h1);
    check_val("op100_uov", 32'(unsigned_overflow), 32'h0);
    load_ir(16'h8260);
    check_val("op100_result", 32'(data_out), 32'h0000);
`endif

    // Randomized control and data against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
      end else begin
        opc = OPCS[$urandom_range(0, 17)];
        din = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : {opc, 8'($urandom)};
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), 1'($urandom), 1'($urandom), din);
      end
    end

    // Mid-run reset with nonzero registers, PC and flags
    load_reg(1, 16'h1234);
    load_ir(16'hA115);
    step(1, 1, 0, 1, 0, 3'd3, 1, 1, 16'h0000);
    idle_step(1'b1);
    async_reset();
    idle_step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
